// File: rtl/udp_jpeg_frame_sched.sv
// Splits a JPEG frame held in DDR3 into UDP packets and hands them to the sender one at a time.
// Optional macro UDP_PKT_GAP_EN inserts GAP_CYCLES idle clocks between the packets of one frame.
module udp_jpeg_frame_sched #(
  parameter int unsigned MAX_PAYLOAD = 1024,
  parameter int unsigned GAP_CYCLES  = 256
) (
  input  logic        i_udp_clk50m,
  input  logic        i_rst,
  input  logic        i_frame_start,
  input  logic [23:0] i_frame_len,
  input  logic        i_send_busy,
  output logic        o_send_en,
  output logic [15:0] o_pkt_len,
  output logic [14:0] o_pkt_rank,
  output logic        o_pkt_last,
  output logic [15:0] o_ipv4_sign,
  output logic        o_frame_busy,
  output logic        o_frame_done,
  output logic        o_frame_err
);

  localparam logic [23:0] MaxPayload = 24'(MAX_PAYLOAD);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StKick,
    StWaitAck,
    StWaitDone,
`ifdef UDP_PKT_GAP_EN
    StGap,
`endif
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [23:0] remaining_q;
  logic [14:0] rank_q;

`ifdef UDP_PKT_GAP_EN
  localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);
  logic [GapW-1:0] gap_cnt_q;
  logic            gap_end;
  assign gap_end = (gap_cnt_q == GapW'(GAP_CYCLES - 1));
`else
  logic unused_gap_cfg;
  assign unused_gap_cfg = ^GAP_CYCLES;
`endif

  always_ff @(posedge i_udp_clk50m) begin
    if (i_rst) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (i_frame_start && (i_frame_len != 24'd0)) state_d = StLoad;
      StLoad:     state_d = StKick;
      StKick:     state_d = StWaitAck;
      StWaitAck:  if (i_send_busy) state_d = StWaitDone;
      StWaitDone: begin
        if (!i_send_busy) begin
`ifdef UDP_PKT_GAP_EN
          state_d = o_pkt_last ? StDone : StGap;
`else
          state_d = o_pkt_last ? StDone : StLoad;
`endif
        end
      end
`ifdef UDP_PKT_GAP_EN
      StGap:      if (gap_end) state_d = StLoad;
`endif
      StDone:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Send request stays up through WAIT_ACK; drops the cycle after busy is seen.
  assign o_send_en    = (state_q == StKick) || (state_q == StWaitAck);
  assign o_frame_busy = (state_q != StIdle) && (state_q != StDone);
  assign o_frame_done = (state_q == StDone);

  always_ff @(posedge i_udp_clk50m) begin
    if (i_rst) begin
      remaining_q <= 24'd0;
      rank_q      <= 15'd0;
      o_pkt_len   <= 16'd0;
      o_pkt_rank  <= 15'd0;
      o_pkt_last  <= 1'b0;
      o_ipv4_sign <= 16'd0;
      o_frame_err <= 1'b0;
`ifdef UDP_PKT_GAP_EN
      gap_cnt_q   <= '0;
`endif
    end else begin
      o_frame_err <= 1'b0;
      case (state_q)
        StIdle: begin
          if (i_frame_start) begin
            if (i_frame_len != 24'd0) begin
              remaining_q <= i_frame_len;
              rank_q      <= 15'd0;
            end else begin
              o_frame_err <= 1'b1;
            end
          end
        end
        StLoad: begin
          o_pkt_len  <= (remaining_q <= MaxPayload) ? remaining_q[15:0] : MaxPayload[15:0];
          o_pkt_last <= (remaining_q <= MaxPayload);
          o_pkt_rank <= rank_q;
        end
        StWaitDone: begin
          if (!i_send_busy) begin
            // o_pkt_len never exceeds remaining, so this cannot underflow.
            remaining_q <= remaining_q - {8'd0, o_pkt_len};
            rank_q      <= rank_q + 15'd1;
            o_ipv4_sign <= o_ipv4_sign + 16'd1;
          end
        end
`ifdef UDP_PKT_GAP_EN
        StGap: gap_cnt_q <= gap_end ? '0 : gap_cnt_q + 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule
